// File: rtl/vga_glyph_if.sv
// Bundles the character-write bus, glyph ROM port and VGA pin outputs of vga_glyph_render.
interface vga_glyph_if;
  logic        char_we;
  logic [2:0]  char_idx;
  logic [3:0]  char_code;
  logic        char_clr;
  logic [3:0]  ra;
  logic [15:0] rd;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        frame_start;

  // System side: CPU write port, ROM data return, VGA connector.
  modport master (
    output char_we, char_idx, char_code, char_clr, rd,
    input  ra, hsync, vsync, rgb, frame_start
  );

  // Renderer side.
  modport slave (
    input  char_we, char_idx, char_code, char_clr, rd,
    output ra, hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/vga_glyph_render.sv
// VGA timing generator plus an 8-character text line rendered from a 3x5 glyph ROM.
// Counters -> stage1 (ROM address, dot select) -> stage2 (pixel), syncs delayed to match.
module vga_glyph_render #(
  parameter int unsigned HVis      = 640,
  parameter int unsigned HFp       = 16,
  parameter int unsigned HSync     = 96,
  parameter int unsigned HBp       = 48,
  parameter int unsigned VVis      = 480,
  parameter int unsigned VFp       = 10,
  parameter int unsigned VSync     = 2,
  parameter int unsigned VBp       = 33,
  parameter int unsigned X0        = 64,
  parameter int unsigned Y0        = 200,
  parameter int unsigned ScaleLog2 = 4,
  parameter logic [2:0]  Color     = 3'b111
) (
  input logic        clk,
  input logic        reset,
  vga_glyph_if.slave bus
);
  localparam int unsigned HTot = HVis + HFp + HSync + HBp;
  localparam int unsigned VTot = VVis + VFp + VSync + VBp;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);

  localparam logic [HW-1:0] HLast   = HW'(HTot - 1);
  localparam logic [VW-1:0] VLast   = VW'(VTot - 1);
  localparam logic [HW-1:0] HsStart = HW'(HVis + HFp);
  localparam logic [HW-1:0] HsEnd   = HW'(HVis + HFp + HSync);
  localparam logic [VW-1:0] VsStart = VW'(VVis + VFp);
  localparam logic [VW-1:0] VsEnd   = VW'(VVis + VFp + VSync);
  localparam logic [HW-1:0] HVisC   = HW'(HVis);
  localparam logic [VW-1:0] VVisC   = VW'(VVis);
  localparam logic [HW-1:0] X0C     = HW'(X0);
  localparam logic [VW-1:0] Y0C     = VW'(Y0);
  localparam logic [HW-1:0] TxtW    = HW'(32 << ScaleLog2);
  localparam logic [VW-1:0] TxtH    = VW'(5 << ScaleLog2);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic [7:0] shadow_valid_q, shadow_valid_d, active_valid_q;
  logic [3:0] shadow_code_q [8];
  logic [3:0] active_code_q [8];

  logic          copy;
  logic          hs0, vs0, in_region;
  logic [HW-1:0] dx;
  logic [VW-1:0] dy;
  logic [2:0]    slot, row;
  logic [1:0]    col;
  logic [3:0]    row4, bit_idx;

  logic       frame_start_q, on_q, hs1_q, vs1_q, hsync_q, vsync_q;
  logic [3:0] ra_q, bit_q;
  logic [2:0] rgb_q;

  // Stage 0: sync windows, reload strobe and text-cell decode from the raw counters.
  always_comb begin
    copy      = (h_cnt == '0) && (v_cnt == VsStart);
    hs0       = !((h_cnt >= HsStart) && (h_cnt < HsEnd));
    vs0       = !((v_cnt >= VsStart) && (v_cnt < VsEnd));
    dx        = h_cnt - X0C;
    dy        = v_cnt - Y0C;
    in_region = (h_cnt >= X0C) && (dx < TxtW) && (v_cnt >= Y0C) && (dy < TxtH) &&
                (h_cnt < HVisC) && (v_cnt < VVisC);
    slot      = dx[ScaleLog2+4 -: 3];
    col       = dx[ScaleLog2+1 -: 2];
    row       = dy[ScaleLog2+2 -: 3];
    row4      = {1'b0, row};
    // Dot index inside the glyph word: rd[14] is row 0 col 0, row-major.
    bit_idx   = 4'd14 - (row4 + {row4[2:0], 1'b0}) - {2'b00, col};
  end

  // Clear happens before write, so a same-cycle clear+write leaves only that slot valid.
  always_comb begin
    shadow_valid_d = shadow_valid_q;
    if (bus.char_clr) shadow_valid_d = '0;
    if (bus.char_we)  shadow_valid_d[bus.char_idx] = 1'b1;
  end

  // Free-running raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HLast) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VLast) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // CPU-written shadow line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_valid_q <= '0;
      shadow_code_q  <= '{default: 4'd0};
    end else begin
      shadow_valid_q <= shadow_valid_d;
      if (bus.char_we) shadow_code_q[bus.char_idx] <= bus.char_code;
    end
  end

  // Active line reloads at vsync start; a write in that same cycle only reaches the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_valid_q <= '0;
      active_code_q  <= '{default: 4'd0};
      frame_start_q  <= 1'b0;
    end else begin
      frame_start_q <= copy;
      if (copy) begin
        active_valid_q <= shadow_valid_q;
        active_code_q  <= shadow_code_q;
      end
    end
  end

  // Stage 1: ROM address, dot enable and bit select; ra holds outside the text line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_q  <= 4'd0;
      on_q  <= 1'b0;
      bit_q <= 4'd0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
    end else begin
      if (in_region) ra_q <= active_code_q[slot];
      on_q  <= in_region && active_valid_q[slot] && (col != 2'd3);
      bit_q <= bit_idx;
      hs1_q <= hs0;
      vs1_q <= vs0;
    end
  end

  // Stage 2: pixel from ROM data, syncs delayed to stay aligned with rgb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= 3'b000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= (on_q && bus.rd[bit_q]) ? Color : 3'b000;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  assign bus.ra          = ra_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.rgb         = rgb_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_glyph_render.sv
// Bench for vga_glyph_render on a shrunken raster (100x37 totals, 2x2 dots) so frames are short.
module tb_vga_glyph_render;
  localparam int HT = 100;  // 80 + 4 + 8 + 8
  localparam int FR = 3700; // HT * 37

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  vga_glyph_if bus ();
  logic [15:0] rom [16];
  assign bus.rd = rom[bus.ra];

  vga_glyph_render #(
    .HVis(80), .HFp(4), .HSync(8), .HBp(8),
    .VVis(30), .VFp(2), .VSync(2), .VBp(3),
    .X0(8), .Y0(10), .ScaleLog2(1), .Color(3'b111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Edges since reset release; after edge k the pins show raster position k-2.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         phase;
    int         x;
    int         y;
    logic [2:0] rgb;
    bit         chk_ra;
    logic [3:0] ra;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int ph, input int x, input int y, input logic [2:0] rgb,
                     input bit chk_ra, input logic [3:0] ra);
    vec_t v;
    v.phase = ph; v.x = x; v.y = y; v.rgb = rgb; v.chk_ra = chk_ra; v.ra = ra;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance until the pins show pixel (x,y); ra then reflects the following pixel.
  task automatic wait_pix(input int x, input int y);
    int target;
    bit hit;
    target = y * HT + x;
    hit = 1'b0;
    for (int n = 0; n < 2 * FR && !hit; n++) begin
      @(posedge clk);
      #1;
      if ((cyc + FR - 2) % FR == target) hit = 1'b1;
    end
    if (!hit) chk($sformatf("wait_pix(%0d,%0d) timeout", x, y), 0, 1);
  endtask

  // sel: 0 hsync, 1 vsync, 2 frame_start. Returns the edge count, or -1 on timeout.
  task automatic wait_for(input int sel, input logic val, output int at);
    logic s;
    at = -1;
    for (int n = 0; n < 2 * FR; n++) begin
      @(posedge clk);
      #1;
      s = (sel == 0) ? bus.hsync : (sel == 1) ? bus.vsync : bus.frame_start;
      if (s === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic put(input logic we, input int idx, input int code, input logic clr);
    bus.char_we   = we;
    bus.char_idx  = 3'(idx);
    bus.char_code = 4'(code);
    bus.char_clr  = clr;
    @(posedge clk);
    #1;
    bus.char_we  = 1'b0;
    bus.char_clr = 1'b0;
  endtask

  task automatic run_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        wait_pix(vecs[i].x, vecs[i].y);
        chk($sformatf("ph%0d rgb(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(bus.rgb),
            32'(vecs[i].rgb));
        if (vecs[i].chk_ra)
          chk($sformatf("ph%0d ra(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(bus.ra),
              32'(vecs[i].ra));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ra"}, 32'(bus.ra), 0);
    chk({tag, " hsync"}, 32'(bus.hsync), 1);
    chk({tag, " vsync"}, 32'(bus.vsync), 1);
    chk({tag, " rgb"}, 32'(bus.rgb), 0);
    chk({tag, " frame_start"}, 32'(bus.frame_start), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    bus.char_we = 1'b0; bus.char_idx = '0; bus.char_code = '0; bus.char_clr = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[1]  = 16'h4000; // top-left dot only
    rom[2]  = 16'h0001; // bottom-right dot only
    rom[8]  = 16'h7FFF; // every dot
    rom[15] = 16'h8000; // unused bit only

    // Text line: x 8..71 (8 px per slot, cols 3 = gap), y 10..19 (2 lines per row).
    // Phase 2: slot0 = code 8.
    add(2, 8, 10, 3'b111, 0, 0);  add(2, 9, 10, 3'b111, 1, 8);
    add(2, 13, 10, 3'b111, 0, 0); add(2, 14, 10, 3'b000, 0, 0);
    add(2, 15, 10, 3'b000, 0, 0); add(2, 16, 10, 3'b000, 0, 0);
    add(2, 7, 15, 3'b000, 0, 0);  add(2, 8, 19, 3'b111, 0, 0);
    add(2, 13, 19, 3'b111, 0, 0); add(2, 8, 20, 3'b000, 0, 0);
    // Phase 3: slot0 = code 1, slot7 = code 2.
    add(3, 8, 10, 3'b111, 1, 1);  add(3, 10, 10, 3'b000, 0, 0);
    add(3, 9, 11, 3'b111, 1, 1);  add(3, 8, 12, 3'b000, 0, 0);
    add(3, 68, 17, 3'b000, 0, 0); add(3, 68, 18, 3'b111, 0, 0);
    add(3, 67, 19, 3'b000, 0, 0); add(3, 69, 19, 3'b111, 0, 0);
    add(3, 70, 19, 3'b000, 0, 0);
    // Phase 4: only slot3 (code 8) and slot5 (code 15, dark) valid.
    add(4, 8, 10, 3'b000, 0, 0);  add(4, 16, 10, 3'b000, 0, 0);
    add(4, 32, 10, 3'b111, 0, 0); add(4, 38, 10, 3'b000, 0, 0);
    add(4, 40, 10, 3'b000, 0, 0); add(4, 48, 10, 3'b000, 1, 15);
    add(4, 64, 10, 3'b000, 0, 0); add(4, 37, 19, 3'b111, 0, 0);
    add(4, 53, 19, 3'b000, 0, 0);
    // Phase 5: slot1 written during the reload cycle appears one frame late.
    add(5, 16, 10, 3'b111, 0, 0); add(5, 32, 10, 3'b111, 0, 0);

    #5 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    put(1'b1, 0, 8, 1'b0);
    wait_for(0, 1'b0, at); chk("hsync first fall", at, 86);
    wait_for(0, 1'b1, at); chk("hsync rise", at, 94);
    wait_for(0, 1'b0, at); chk("hsync second fall", at, 186);
    wait_pix(8, 10);
    chk("rgb before reload", 32'(bus.rgb), 0);

    wait_for(2, 1'b1, at); chk("frame_start first", at, 3201);
    chk("vsync high at reload", 32'(bus.vsync), 1);
    @(posedge clk); #1;
    chk("frame_start one clk", 32'(bus.frame_start), 0);
    chk("vsync fall at 3202", 32'(bus.vsync), 0);
    wait_for(1, 1'b1, at); chk("vsync rise", at, 3402);
    run_phase(2);

    put(1'b1, 0, 1, 1'b0);
    put(1'b1, 7, 2, 1'b0);
    wait_for(2, 1'b1, at); chk("frame_start period", at, 3201 + FR);
    run_phase(3);

    for (int i = 0; i < 8; i++) put(1'b1, i, 8, 1'b0);
    put(1'b1, 3, 8, 1'b1);
    put(1'b1, 5, 15, 1'b0);
    wait_pix(98, 31);
    put(1'b1, 1, 8, 1'b0);
    chk("write on reload cycle", 32'(bus.frame_start), 1);
    run_phase(4);
    run_phase(5);

    wait_pix(33, 15);
    chk("lit before mid-frame reset", 32'(bus.rgb), 7);
    reset = 1'b1;
    #2;
    chk_reset_outputs("mid reset");
    @(negedge clk);
    reset = 1'b0;
    wait_for(0, 1'b0, at); chk("hsync fall after reset", at, 86);
    wait_for(2, 1'b1, at); chk("frame_start after reset", at, 3201);
    wait_pix(33, 15);
    chk("buffer empty after reset", 32'(bus.rgb), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
